armleocpu_decode: RTL and testbench

Decode stage between `armleocpu_fetch` and execute. Accepts one instruction per cycle from fetch and holds up to two entries in a skid buffer, so `e2f_ready` comes from a register rather than from execute's combinational ready. Pre-decodes each entry into class, register indices, funct fields and a sign-extended immediate, then presents it to execute with a valid/ready handshake. Wrong-path entries are dropped when execute redirects.

---
 rtl/armleocpu_decode_pkg.sv | 52 +++++
 rtl/armleocpu_decode_imm.sv | 27 ++
 rtl/armleocpu_decode.sv | 144 ++++++++++++++
 tb/tb_armleocpu_decode.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/armleocpu_decode_pkg.sv
// Shared decode definitions for the decode stage and execute.
// Holds the opcode class encoding, the RV32 base opcode constants and a
// helper that maps a 7-bit opcode onto its class (unknown opcodes -> ClsNone).
package armleocpu_decode_pkg;

  typedef enum logic [3:0] {
    ClsNone    = 4'd0,
    ClsLui     = 4'd1,
    ClsAuipc   = 4'd2,
    ClsJal     = 4'd3,
    ClsJalr    = 4'd4,
    ClsBranch  = 4'd5,
    ClsLoad    = 4'd6,
    ClsStore   = 4'd7,
    ClsOpimm   = 4'd8,
    ClsOp      = 4'd9,
    ClsMiscmem = 4'd10,
    ClsSystem  = 4'd11
  } decode_class_e;

  localparam logic [6:0] OpcLui     = 7'b0110111;
  localparam logic [6:0] OpcAuipc   = 7'b0010111;
  localparam logic [6:0] OpcJal     = 7'b1101111;
  localparam logic [6:0] OpcJalr    = 7'b1100111;
  localparam logic [6:0] OpcBranch  = 7'b1100011;
  localparam logic [6:0] OpcLoad    = 7'b0000011;
  localparam logic [6:0] OpcStore   = 7'b0100011;
  localparam logic [6:0] OpcOpimm   = 7'b0010011;
  localparam logic [6:0] OpcOp      = 7'b0110011;
  localparam logic [6:0] OpcMiscmem = 7'b0001111;
  localparam logic [6:0] OpcSystem  = 7'b1110011;

  function automatic decode_class_e opcode_class(input logic [6:0] opcode);
    decode_class_e cls;
    case (opcode)
      OpcLui:     cls = ClsLui;
      OpcAuipc:   cls = ClsAuipc;
      OpcJal:     cls = ClsJal;
      OpcJalr:    cls = ClsJalr;
      OpcBranch:  cls = ClsBranch;
      OpcLoad:    cls = ClsLoad;
      OpcStore:   cls = ClsStore;
      OpcOpimm:   cls = ClsOpimm;
      OpcOp:      cls = ClsOp;
      OpcMiscmem: cls = ClsMiscmem;
      OpcSystem:  cls = ClsSystem;
      default:    cls = ClsNone;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/armleocpu_decode_imm.sv
// Immediate generator for the decode stage (combinational).
// Ports:
//   instr - raw 32-bit instruction word
//   cls   - decoded opcode class
//   imm   - immediate, formatted and sign-extended for the class; 0 for classes
//           without an immediate (OP, MISCMEM, NONE)
module armleocpu_decode_imm
  import armleocpu_decode_pkg::*;
(
  input  logic [31:0]   instr,
  input  decode_class_e cls,
  output logic [31:0]   imm
);

  always_comb begin
    imm = '0;
    case (cls)
      ClsLui, ClsAuipc: imm = {instr[31:12], 12'b0};
      ClsJal: imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      ClsJalr, ClsLoad, ClsOpimm, ClsSystem: imm = {{20{instr[31]}}, instr[31:20]};
      ClsStore: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ClsBranch: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/armleocpu_decode.sv
// Decode stage: 2-entry skid buffer between fetch and execute plus pre-decode
// of the head entry (class, register fields, funct fields, immediate).
// Optional feature macro: ARMLEOCPU_DECODE_ILLEGAL_CHECK_EN - when defined,
// unknown opcodes (or instr[1:0] != 2'b11) raise d2e_illegal; otherwise
// d2e_illegal is tied low and unknown opcodes decode to class NONE.
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   f2e_*                      - fetch word in (valid, instr, pc, exc_start, cause)
//   e2f_ready                  - registered, high when an entry is free
//   e2d_kill, e2d_ready        - execute redirect / consume head entry
//   d2e_*                      - head entry and its decoded fields
module armleocpu_decode
  import armleocpu_decode_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f2e_valid,
  input  logic [31:0] f2e_instr,
  input  logic [31:0] f2e_pc,
  input  logic        f2e_exc_start,
  input  logic [31:0] f2e_cause,
  output logic        e2f_ready,
  input  logic        e2d_kill,
  input  logic        e2d_ready,
  output logic        d2e_valid,
  output logic [31:0] d2e_pc,
  output logic [31:0] d2e_instr,
  output logic [3:0]  d2e_class,
  output logic [4:0]  d2e_rd,
  output logic [4:0]  d2e_rs1,
  output logic [4:0]  d2e_rs2,
  output logic [2:0]  d2e_funct3,
  output logic [6:0]  d2e_funct7,
  output logic [31:0] d2e_imm,
  output logic        d2e_exc_start,
  output logic [31:0] d2e_cause,
  output logic        d2e_illegal
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] CountFull = 2'(DEPTH);

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      cause_mem [DEPTH];
  logic [DEPTH-1:0] exc_mem;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            ready_q, ready_d;

  logic push, pop;

  assign d2e_valid = (count_q != 2'd0);
  assign e2f_ready = ready_q;

  // Kill gates both sides so a wrong-path word is never stored or consumed.
  assign push = f2e_valid && ready_q && !e2d_kill;
  assign pop  = d2e_valid && e2d_ready && !e2d_kill;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (e2d_kill) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
    ready_d = (count_d < CountFull);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Payload needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= f2e_instr;
      pc_mem[wr_ptr_q]    <= f2e_pc;
      cause_mem[wr_ptr_q] <= f2e_cause;
      exc_mem[wr_ptr_q]   <= f2e_exc_start;
    end
  end

  logic [31:0]   head_instr;
  logic          head_exc;
  decode_class_e opc_cls;
  decode_class_e head_cls;

  assign head_instr = instr_mem[rd_ptr_q];
  assign head_exc   = exc_mem[rd_ptr_q];
  assign opc_cls    = opcode_class(head_instr[6:0]);

`ifdef ARMLEOCPU_DECODE_ILLEGAL_CHECK_EN
  logic known;
  assign known       = (opc_cls != ClsNone) && (head_instr[1:0] == 2'b11);
  assign head_cls    = (head_exc || !known) ? ClsNone : opc_cls;
  assign d2e_illegal = !head_exc && !known;
`else
  assign head_cls    = head_exc ? ClsNone : opc_cls;
  assign d2e_illegal = 1'b0;
`endif

  armleocpu_decode_imm u_imm (
    .instr (head_instr),
    .cls   (head_cls),
    .imm   (d2e_imm)
  );

  assign d2e_pc        = pc_mem[rd_ptr_q];
  assign d2e_instr     = head_instr;
  assign d2e_class     = head_cls;
  assign d2e_rd        = head_instr[11:7];
  assign d2e_rs1       = head_instr[19:15];
  assign d2e_rs2       = head_instr[24:20];
  assign d2e_funct3    = head_instr[14:12];
  assign d2e_funct7    = head_instr[31:25];
  assign d2e_exc_start = head_exc;
  assign d2e_cause     = cause_mem[rd_ptr_q];

endmodule

// File: tb/tb_armleocpu_decode.sv
module tb_armleocpu_decode;

`ifdef ARMLEOCPU_DECODE_ILLEGAL_CHECK_EN
  localparam logic ExpIll = 1'b1;
`else
  localparam logic ExpIll = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        f2e_valid;
  logic [31:0] f2e_instr;
  logic [31:0] f2e_pc;
  logic        f2e_exc_start;
  logic [31:0] f2e_cause;
  logic        e2f_ready;
  logic        e2d_kill;
  logic        e2d_ready;
  logic        d2e_valid;
  logic [31:0] d2e_pc;
  logic [31:0] d2e_instr;
  logic [3:0]  d2e_class;
  logic [4:0]  d2e_rd;
  logic [4:0]  d2e_rs1;
  logic [4:0]  d2e_rs2;
  logic [2:0]  d2e_funct3;
  logic [6:0]  d2e_funct7;
  logic [31:0] d2e_imm;
  logic        d2e_exc_start;
  logic [31:0] d2e_cause;
  logic        d2e_illegal;

  int total = 0;
  int bad = 0;

  armleocpu_decode #(.DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .f2e_valid     (f2e_valid),
    .f2e_instr     (f2e_instr),
    .f2e_pc        (f2e_pc),
    .f2e_exc_start (f2e_exc_start),
    .f2e_cause     (f2e_cause),
    .e2f_ready     (e2f_ready),
    .e2d_kill      (e2d_kill),
    .e2d_ready     (e2d_ready),
    .d2e_valid     (d2e_valid),
    .d2e_pc        (d2e_pc),
    .d2e_instr     (d2e_instr),
    .d2e_class     (d2e_class),
    .d2e_rd        (d2e_rd),
    .d2e_rs1       (d2e_rs1),
    .d2e_rs2       (d2e_rs2),
    .d2e_funct3    (d2e_funct3),
    .d2e_funct7    (d2e_funct7),
    .d2e_imm       (d2e_imm),
    .d2e_exc_start (d2e_exc_start),
    .d2e_cause     (d2e_cause),
    .d2e_illegal   (d2e_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    e2d_ready = 1'b1;
    tick();
    e2d_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; f2e_valid = 1'b0; e2d_kill = 1'b0; e2d_ready = 1'b0;
    f2e_exc_start = 1'b0; f2e_cause = '0; f2e_instr = '0; f2e_pc = '0;
    tick(); tick();
    total++; if (d2e_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", d2e_valid); end
    total++; if (e2f_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", e2f_ready); end
    rst_n = 1'b1;
    tick();
    total++; if (e2f_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_rise got=%b exp=1", e2f_ready); end
    total++; if (d2e_valid !== 1'b0) begin bad++; $display("FAIL rst_valid_after got=%b exp=0", d2e_valid); end
  endtask

  task automatic test_push_addi();
    f2e_valid = 1'b1; f2e_pc = 32'h2000; f2e_instr = 32'h0050_0093;
    tick();
    f2e_valid = 1'b0;
    total++; if (d2e_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b exp=1", d2e_valid); end
    total++; if (d2e_class !== 4'd8) begin bad++; $display("FAIL addi_class got=%0d exp=8", d2e_class); end
    total++; if (d2e_rd !== 5'd1) begin bad++; $display("FAIL addi_rd got=%0d exp=1", d2e_rd); end
    total++; if (d2e_rs1 !== 5'd0) begin bad++; $display("FAIL addi_rs1 got=%0d exp=0", d2e_rs1); end
    total++; if (d2e_imm !== 32'd5) begin bad++; $display("FAIL addi_imm got=%h exp=5", d2e_imm); end
    total++; if (d2e_pc !== 32'h2000) begin bad++; $display("FAIL addi_pc got=%h exp=2000", d2e_pc); end
    total++; if (d2e_illegal !== 1'b0) begin bad++; $display("FAIL addi_illegal got=%b exp=0", d2e_illegal); end
    total++; if (e2f_ready !== 1'b1) begin bad++; $display("FAIL addi_ready got=%b exp=1", e2f_ready); end
    pop_one();
    total++; if (d2e_valid !== 1'b0) begin bad++; $display("FAIL addi_pop_valid got=%b exp=0", d2e_valid); end
  endtask

  task automatic test_fill_stall();
    f2e_valid = 1'b1; e2d_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      f2e_pc = 32'h2000 + 32'(4 * i);
      f2e_instr = 32'h0000_0013;
      tick();
      if (i == 0) begin
        total++; if (e2f_ready !== 1'b1) begin bad++; $display("FAIL fill_ready1 got=%b exp=1", e2f_ready); end
      end else begin
        total++; if (e2f_ready !== 1'b0) begin bad++; $display("FAIL fill_ready%0d got=%b exp=0", i + 1, e2f_ready); end
      end
      total++; if (d2e_pc !== 32'h2000) begin bad++; $display("FAIL fill_hold_pc%0d got=%h exp=2000", i, d2e_pc); end
    end
    f2e_valid = 1'b0; e2d_ready = 1'b1;
    tick();
    total++; if (d2e_pc !== 32'h2004) begin bad++; $display("FAIL fill_second_pc got=%h exp=2004", d2e_pc); end
    total++; if (e2f_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_free got=%b exp=1", e2f_ready); end
    tick();
    e2d_ready = 1'b0;
    total++; if (d2e_valid !== 1'b0) begin bad++; $display("FAIL fill_third_dropped got=%b exp=0", d2e_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] instrs [4];
    logic [3:0]  classes [4];
    logic [31:0] imms [4];
    instrs[0] = 32'h1234_52B7; classes[0] = 4'd1; imms[0] = 32'h1234_5000;
    instrs[1] = 32'h0020_A423; classes[1] = 4'd7; imms[1] = 32'h0000_0008;
    instrs[2] = 32'h4020_81B3; classes[2] = 4'd9; imms[2] = 32'h0000_0000;
    instrs[3] = 32'hFE00_0EE3; classes[3] = 4'd5; imms[3] = 32'hFFFF_FFFC;
    f2e_valid = 1'b1; e2d_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f2e_pc = 32'h100 + 32'(4 * i);
      f2e_instr = instrs[i];
      tick();
      total++; if (d2e_pc !== 32'h100 + 32'(4 * i)) begin bad++; $display("FAIL b2b_pc%0d got=%h exp=%h", i, d2e_pc, 32'h100 + 32'(4 * i)); end
      total++; if (d2e_class !== classes[i]) begin bad++; $display("FAIL b2b_class%0d got=%0d exp=%0d", i, d2e_class, classes[i]); end
      total++; if (d2e_imm !== imms[i]) begin bad++; $display("FAIL b2b_imm%0d got=%h exp=%h", i, d2e_imm, imms[i]); end
      if (i == 2) begin
        total++; if (d2e_rs2 !== 5'd2) begin bad++; $display("FAIL b2b_sub_rs2 got=%0d exp=2", d2e_rs2); end
        total++; if (d2e_funct7 !== 7'h20) begin bad++; $display("FAIL b2b_sub_funct7 got=%h exp=20", d2e_funct7); end
        total++; if (d2e_rd !== 5'd3) begin bad++; $display("FAIL b2b_sub_rd got=%0d exp=3", d2e_rd); end
      end
      if (i == 1) begin
        total++; if (d2e_funct3 !== 3'd2) begin bad++; $display("FAIL b2b_sw_funct3 got=%0d exp=2", d2e_funct3); end
      end
    end
    f2e_valid = 1'b0;
    tick();
    e2d_ready = 1'b0;
    total++; if (d2e_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", d2e_valid); end
  endtask

  task automatic test_branch_jal();
    e2d_ready = 1'b0; f2e_valid = 1'b1;
    f2e_pc = 32'h3000; f2e_instr = 32'hFE00_0EE3;
    tick();
    total++; if (d2e_class !== 4'd5) begin bad++; $display("FAIL beq_class got=%0d exp=5", d2e_class); end
    total++; if (d2e_imm !== 32'hFFFF_FFFC) begin bad++; $display("FAIL beq_imm got=%h exp=fffffffc", d2e_imm); end
    f2e_pc = 32'h3004; f2e_instr = 32'h8000_00EF; e2d_ready = 1'b1;
    tick();
    f2e_valid = 1'b0;
    total++; if (d2e_class !== 4'd3) begin bad++; $display("FAIL jal_class got=%0d exp=3", d2e_class); end
    total++; if (d2e_imm !== 32'hFFF0_0000) begin bad++; $display("FAIL jal_imm got=%h exp=fff00000", d2e_imm); end
    total++; if (d2e_pc !== 32'h3004) begin bad++; $display("FAIL jal_pc got=%h exp=3004", d2e_pc); end
    tick();
    e2d_ready = 1'b0;
  endtask

  task automatic test_kill();
    e2d_ready = 1'b0; f2e_valid = 1'b1;
    f2e_pc = 32'h4000; f2e_instr = 32'h0000_0013; tick();
    f2e_pc = 32'h4004; tick();
    total++; if (e2f_ready !== 1'b0) begin bad++; $display("FAIL kill_full_ready got=%b exp=0", e2f_ready); end
    f2e_pc = 32'h4008; e2d_kill = 1'b1;
    tick();
    e2d_kill = 1'b0; f2e_valid = 1'b0;
    total++; if (d2e_valid !== 1'b0) begin bad++; $display("FAIL kill_valid got=%b exp=0", d2e_valid); end
    total++; if (e2f_ready !== 1'b1) begin bad++; $display("FAIL kill_ready got=%b exp=1", e2f_ready); end
    tick();
    total++; if (d2e_valid !== 1'b0) begin bad++; $display("FAIL kill_word_lost got=%b exp=0", d2e_valid); end
    // Kill while fetch word would otherwise be accepted.
    f2e_valid = 1'b1; f2e_pc = 32'h5000; tick();
    f2e_pc = 32'h5004; e2d_kill = 1'b1; e2d_ready = 1'b1;
    tick();
    e2d_kill = 1'b0; f2e_valid = 1'b0; e2d_ready = 1'b0;
    tick();
    total++; if (d2e_valid !== 1'b0) begin bad++; $display("FAIL kill_gates_push got=%b exp=0", d2e_valid); end
    f2e_valid = 1'b1; f2e_pc = 32'h6000; tick();
    f2e_valid = 1'b0;
    total++; if (d2e_pc !== 32'h6000) begin bad++; $display("FAIL kill_restart_pc got=%h exp=6000", d2e_pc); end
    pop_one();
  endtask

  task automatic test_exception();
    f2e_valid = 1'b1; f2e_exc_start = 1'b1; f2e_cause = 32'd7;
    f2e_pc = 32'h7000; f2e_instr = 32'h0050_0093;
    tick();
    f2e_valid = 1'b0; f2e_exc_start = 1'b0; f2e_cause = '0;
    total++; if (d2e_exc_start !== 1'b1) begin bad++; $display("FAIL exc_start got=%b exp=1", d2e_exc_start); end
    total++; if (d2e_cause !== 32'd7) begin bad++; $display("FAIL exc_cause got=%0d exp=7", d2e_cause); end
    total++; if (d2e_imm !== 32'd0) begin bad++; $display("FAIL exc_imm got=%h exp=0", d2e_imm); end
    total++; if (d2e_class !== 4'd0) begin bad++; $display("FAIL exc_class got=%0d exp=0", d2e_class); end
    total++; if (d2e_illegal !== 1'b0) begin bad++; $display("FAIL exc_illegal got=%b exp=0", d2e_illegal); end
    pop_one();
  endtask

  task automatic test_illegal();
    logic [31:0] words [2];
    words[0] = 32'h0000_007F;
    words[1] = 32'h0000_0000;
    for (int i = 0; i < 2; i++) begin
      f2e_valid = 1'b1; f2e_pc = 32'h8000; f2e_instr = words[i];
      tick();
      f2e_valid = 1'b0;
      total++; if (d2e_illegal !== ExpIll) begin bad++; $display("FAIL ill_flag%0d got=%b exp=%b", i, d2e_illegal, ExpIll); end
      total++; if (d2e_class !== 4'd0) begin bad++; $display("FAIL ill_class%0d got=%0d exp=0", i, d2e_class); end
      total++; if (d2e_imm !== 32'd0) begin bad++; $display("FAIL ill_imm%0d got=%h exp=0", i, d2e_imm); end
      pop_one();
    end
  endtask

  task automatic test_reset_mid();
    f2e_valid = 1'b1; f2e_pc = 32'h9000; f2e_instr = 32'h0000_0013; tick();
    f2e_pc = 32'h9004; tick();
    f2e_valid = 1'b0; rst_n = 1'b0;
    tick();
    total++; if (d2e_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", d2e_valid); end
    total++; if (e2f_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", e2f_ready); end
    rst_n = 1'b1;
    tick();
    total++; if (e2f_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_rise got=%b exp=1", e2f_ready); end
    total++; if (d2e_valid !== 1'b0) begin bad++; $display("FAIL midrst_empty got=%b exp=0", d2e_valid); end
  endtask

  initial begin
    test_reset();
    test_push_addi();
    test_fill_stall();
    test_back_to_back();
    test_branch_jal();
    test_kill();
    test_exception();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
